// File: rtl/muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_seq_pkg : shared types and constants for the RV32M mul/div sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MUL   = 3'b000,
    MULHU = 3'b011,
    DIVU  = 3'b101,
    REMU  = 3'b111
  } MulDivOp_Enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } MulDivState_Enum;

  localparam int MULDIV_XLEN = 32;
  // Start-cycle to done-cycle distance for a full iterative op.
  localparam int MULDIV_LAT  = MULDIV_XLEN + 1;

  function automatic logic muldiv_is_legal(input logic [2:0] f);
    return (f == MUL) || (f == MULHU) || (f == DIVU) || (f == REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step : one combinational shift-add or restoring-divide iteration
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shr;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  // Multiply: carry-out of the add becomes the top bit shifted into hi.
  assign w_sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);

  // Divide: remainder stays below the divisor, so the difference fits XLEN.
  assign w_shr  = {hi_i, lo_i[XLEN-1]};
  assign w_fits = (w_shr >= {1'b0, b_i});
  assign w_diff = w_shr[XLEN-1:0] - b_i;

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (is_div_i) begin
      hi_o = w_fits ? w_diff : w_shr[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], w_fits};
    end else begin
      hi_o = w_sum[XLEN:1];
      lo_o = {w_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : iterative RV32M unsigned multiply/divide sequencer (1 bit/cycle)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  MulDivState_Enum state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       func_q, func_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [XLEN-1:0]  w_hi_nxt;
  logic [XLEN-1:0]  w_lo_nxt;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (func_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (w_hi_nxt),
    .lo_o     (w_lo_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    case (state_q)
      RUN: begin
        hi_d  = w_hi_nxt;
        lo_d  = w_lo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d   = DONE;
          illegal_d = 1'b0;
          result_d  = (func_q == MULHU || func_q == REMU) ? w_hi_nxt : w_lo_nxt;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          func_d = func3;
          b_d    = op_b;
          cnt_d  = '0;
          hi_d   = '0;
          lo_d   = op_a;
          if (!muldiv_is_legal(func3)) begin
            state_d   = DONE;
            result_d  = '0;
            illegal_d = 1'b1;
          end else if (func3[2] && (op_b == '0)) begin
            state_d   = DONE;
            result_d  = (func3 == DIVU) ? '1 : op_a;
            illegal_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase

    if (kill) begin
      state_d   = IDLE;
      cnt_d     = cnt_q;
      func_d    = func_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      result_d  = result_q;
      illegal_d = illegal_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func_q    <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : directed self-checking bench for muldiv_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int total;
  int bad;
  int lat;
  int busy_cnt;
  int done_seen;

  muldiv_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .func3   (func3),
    .op_a    (op_a),
    .op_b    (op_b),
    .kill    (kill),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request through the accept edge, then scramble the operand bus.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    func3 = f;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Bounded wait for done; lat counts cycles from the start cycle.
  task automatic wait_done();
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ill);
    issue(f, a, b);
    wait_done();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  task automatic watch_no_done(input int cycles);
    done_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) done_seen++;
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    func3 = 3'b000;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mul", 3'b000, 32'h0001_0003, 32'h0000_0005, 33, 32'h0005_000F, 1'b0);
    tick();

    // MULHU followed by DIVU issued in the DONE cycle.
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
    run_op("divu_b2b", 3'b101, 32'd100, 32'd7, 33, 32'd14, 1'b0);
    run_op("remu", 3'b111, 32'd100, 32'd7, 33, 32'd2, 1'b0);
    tick();

    run_op("divu_z", 3'b101, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_z", 3'b111, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 1'b0);
    run_op("ill", 3'b100, 32'h0000_00AA, 32'h0000_0055, 1, 32'd0, 1'b1);
    tick();
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0FFF_FFFF, 1'b0);
    tick();

    // Kill at iteration 10: abort, no done, previous result kept.
    issue(3'b000, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_ready", {31'd0, ready}, 32'd1);
    watch_no_done(40);
    chk("kill_nodone", 32'(done_seen), 32'd0);
    chk("kill_result", result, 32'h0FFF_FFFF);

    // kill with start in the same cycle: not accepted.
    start = 1'b1;
    kill  = 1'b1;
    func3 = 3'b000;
    op_a  = 32'd3;
    op_b  = 32'd3;
    tick();
    start = 1'b0;
    kill  = 1'b0;
    chk("killstart_busy", {31'd0, busy}, 32'd0);
    watch_no_done(40);
    chk("killstart_nodone", 32'(done_seen), 32'd0);

    // Reset at iteration 20.
    issue(3'b000, 32'd11, 32'd13);
    for (int i = 0; i < 19; i++) tick();
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_illegal", {31'd0, illegal}, 32'd0);
    tick();
    run_op("mul_after", 3'b000, 32'd11, 32'd13, 33, 32'd143, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multi-cycle multiply/divide sequencer for RV32M unsigned ops, sitting beside the single-cycle ALU in EX.
- Decode routes RV32M instructions here instead of the ALU.
- The block accepts an op, iterates one bit per cycle, raises busy so the hazard logic freezes the pipeline, then presents the result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width; power of two, >= 8.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when ready=1
func3  input  3  RV32M func3 of requesting instruction
op_a  input  XLEN  rs1 value (multiplicand / dividend)
op_b  input  XLEN  rs2 value (multiplier / divisor)
kill  input  1  pipeline flush; aborts any op in flight
ready  output  1  can accept start this cycle
busy  output  1  op in flight; drives pipeline stall
done  output  1  one-cycle pulse; result/illegal valid
result  output  XLEN  op result; held until next done
illegal  output  1  func3 unsupported; valid with done

Behaviour:
- Reset (rst=1 at edge), whatever the state:
  - state=IDLE, ready=1, busy=0, done=0, result=0, illegal=0.
  - Counter and working registers are cleared.
- Supported func3:
  - MUL=000: low XLEN bits of a*b.
  - MULHU=011: high XLEN bits of a*b.
  - DIVU=101: floor(a/b).
  - REMU=111: a mod b.
  - Any other func3 is illegal.
- States: IDLE, RUN, DONE.
  - ready=1 in IDLE and DONE.
  - busy=1 in RUN.
  - done=1 in DONE only.
- Accept rules:
  - Start is accepted at edge E0 when ready=1, start=1 and kill=0.
  - On accept, latch func3, op_a and op_b, and clear counter=0.
- Next state after accept:
  - Legal op with nonzero divisor (or any mul): RUN.
  - DIVU/REMU with op_b=0: DONE directly. DIVU gives all-ones; REMU gives op_a.
  - Illegal func3: DONE directly, result=0, illegal=1.
- RUN:
  - One iteration per edge, counter increments each edge.
  - After the iteration with counter=XLEN-1, go to DONE.
  - Normal op timing: accepted at E0, iterations at E1..E32, done=1 in the cycle after E32.
  - Latency from start cycle to done cycle is XLEN+1 cycles for normal ops and 1 cycle for the short-cut cases.
- Multiply: shift-add on a 2*XLEN product register, initialised {0, op_a}.
  - Each step: if P[0], add op_b to the upper half with carry-out kept (XLEN+1 bits).
  - Then shift right by 1.
- Divide: restoring divide.
  - Remainder register R (XLEN+1 bits) = 0; quotient register Q = op_a.
  - Each step: shift {R,Q} left by 1 and trial-subtract op_b from R.
  - If no borrow, keep the difference and set Q[0]=1; else restore R.
- Output registers:
  - result and illegal are written at the edge that enters DONE.
  - They hold until the next entry to DONE.
- DONE lasts exactly one cycle, then IDLE.
  - If start=1 in DONE (kill=0), the new op is accepted at that same edge; back-to-back issue is allowed.
- kill=1 at an edge in any state:
  - Next state is IDLE and done stays 0.
  - result and illegal are unchanged.
  - kill overrides a simultaneous start.
  - kill in DONE does not retract the done already asserted in that cycle.
- start=1 while ready=0 is ignored. No queuing.
- Operand inputs may change after acceptance. Only the latched copies are used.

Decomposition:
- Add to my_pkg:
  - MulDivOp_Enum (MUL=3'b000, MULHU=3'b011, DIVU=3'b101, REMU=3'b111).
  - MulDivState_Enum (IDLE, RUN, DONE).
  - Localparam MULDIV_LAT = XLEN+1, for the hazard unit and bench.
- Sub-module muldiv_step (combinational): one iteration of either algorithm.
  - Inputs: mode and working registers. Outputs: next working registers.
  - The FSM and counter stay in muldiv_seq.

Test Plan:
- Reset: rst=1 for 2 cycles, then check ready=1, busy=0, done=0, result=0, illegal=0.
- MUL: func3=000, a=0x0001_0003, b=0x0000_0005. Expect busy for 32 cycles, done at start+33, result=0x0005_000F, illegal=0.
- MULHU: a=b=0xFFFF_FFFF, then DIVU a=100 b=7 issued in the DONE cycle. Expect result=0xFFFF_FFFE, immediately followed by 33 cycles later result=14; REMU a=100 b=7 -> result=2.
- Divide by zero: DIVU a=0x1234 b=0 gives done at start+1 with result=0xFFFF_FFFF. REMU a=0x1234 b=0 gives result=0x1234.
- Illegal func3=3'b100: expect done at start+1, result=0, illegal=1, never busy.
- Kill mid-op:
  - MUL with kill at iteration 10: next cycle IDLE and no done pulse; result keeps its previous value.
  - kill with start together: not accepted.
  - rst at iteration 20: outputs return to reset values next cycle.
